// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state type
// and the default operand width.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_adder.sv
// One-bit full adder cell used by the serial adder; purely combinational.
module adder (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);

    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per operation.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic [1:0]       fsm_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] sum_sr;
    logic             carry;

    logic             cell_s;
    logic             cell_co;
    logic [WIDTH-1:0] sum_next;

    adder u_cell (
        .A  (a_sr[0]),
        .B  (b_sr[0]),
        .Ci (carry),
        .S  (cell_s),
        .Co (cell_co)
    );

    // New sum bits enter at the top; on the last cycle this is the full result.
    assign sum_next  = {cell_s, sum_sr};
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        carry    <= ci;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    sum_sr <= sum_next[WIDTH-1:1];
                    carry  <= cell_co;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here
                        sum       <= sum_next;
                        co        <= cell_co;
                        ovf       <= carry ^ cell_co;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus a randomized run
// against a cycle-level behavioural model of the handshake and arithmetic.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         ci = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    logic [1:0]   fsm_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit check_en  = 1'b0;

    always #25 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf),
        .fsm_state (fsm_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: mode 0 idle, 1 busy adding, 2 holding result.
    int           m_mode = 0;
    int           m_cnt = 0;
    int           m_accepts = 0;
    logic [W-1:0] m_sum = '0, m_sum_p = '0;
    logic         m_co = 1'b0, m_co_p = 1'b0;
    logic         m_ovf = 1'b0, m_ovf_p = 1'b0;

    always @(posedge clk) begin
        logic [W:0] t;
        if (rst) begin
            m_mode = 0;
            m_cnt  = 0;
            m_sum  = '0;
            m_co   = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            case (m_mode)
                0: if (in_valid) begin
                    t       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
                    m_sum_p = t[W-1:0];
                    m_co_p  = t[W];
                    m_ovf_p = (a[W-1] == b[W-1]) && (m_sum_p[W-1] != a[W-1]);
                    m_mode  = 1;
                    m_cnt   = 0;
                    m_accepts++;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == W) begin
                        m_mode = 2;
                        m_sum  = m_sum_p;
                        m_co   = m_co_p;
                        m_ovf  = m_ovf_p;
                    end
                end
                default: if (out_ready) m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, m_mode == 0});
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_mode == 2});
            chk("result", {22'b0, ovf, co, sum}, {22'b0, m_ovf, m_co, m_sum});
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                          input logic [W-1:0] es, input logic eco, input logic eovf,
                          input int hold);
        int lat;
        wait_ready();
        a = ta; b = tb_v; ci = tci; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("latency", lat, W);
        chk("lit_sum", {24'b0, sum}, {24'b0, es});
        chk("lit_co", {31'b0, co}, {31'b0, eco});
        chk("lit_ovf", {31'b0, ovf}, {31'b0, eovf});
        chk("model_pin", {22'b0, m_ovf, m_co, m_sum}, {22'b0, eovf, eco, es});
        repeat (hold) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            chk("hold_sum", {24'b0, sum}, {24'b0, es});
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("consumed", {31'b0, out_valid}, 32'd0);
        chk("retained_sum", {24'b0, sum}, {24'b0, es});
    endtask

    initial begin
        int base;
        int cyc;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", {22'b0, ovf, co, sum}, 32'd0);
        rst = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 5);
        run_op(8'hA5, 8'h3C, 1'b1, 8'hE2, 1'b0, 1'b0, 2);

        // Abort an operation in its fourth RUN cycle.
        wait_ready();
        a = 8'h55; b = 8'h22; ci = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_sum", {24'b0, sum}, 32'd0);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0);

        base = m_accepts;
        cyc = 0;
        while ((m_accepts - base) < 1000 && cyc < 60000) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            ci        = 1'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("random_ops_done", {31'b0, (m_accepts - base) >= 1000}, 32'd1);
        repeat (W + 3) @(negedge clk);
        check_en = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port: in_valid  input  1  operand set offered.
REQ-005 SHALL have port: in_ready  output  1  block accepts an operand set this cycle.
REQ-006 SHALL have port: a  input  WIDTH  operand A.
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: ci  input  1  carry-in for bit 0.
REQ-009 SHALL have port: out_valid  output  1  result held and valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port: sum  output  WIDTH  A+B+ci modulo 2^WIDTH.
REQ-012 SHALL have port: co  output  1  carry out of bit WIDTH-1.
REQ-013 SHALL have port: ovf  output  1  two's-complement overflow (carry into MSB xor co).

Function
REQ-014 SHALL add one bit per cycle through a single one-bit full-adder cell, LSB first, with a carry register feeding the cell's carry-in.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; encoding is free.
REQ-016 IDLE: in_ready=1; on in_valid=1, latch a, b, ci into shift/carry registers, clear bit counter, go to RUN.
REQ-017 RUN: in_ready=0; each cycle capture cell S into sum shift register (MSB-in), cell Co into carry register, shift operands right, increment counter.
REQ-018 RUN SHALL last exactly WIDTH cycles; after the cycle processing bit WIDTH-1, go to DONE.
REQ-019 SHALL register the carry into bit WIDTH-1 during the final RUN cycle for ovf.
REQ-020 DONE: out_valid=1; sum, co, ovf stable until out_ready=1; on out_ready=1 go to IDLE.
REQ-021 Latency: in_valid accepted at edge N -> out_valid=1 after edge N+WIDTH, held until consumed.
REQ-022 in_valid while in RUN or DONE SHALL be ignored and nothing latched; no queuing.
REQ-023 out_ready while not in DONE SHALL have no effect.
REQ-024 No back-to-back overlap: the IDLE cycle after DONE is mandatory; throughput is one result per WIDTH+2 cycles.
REQ-025 Counter width SHALL be $clog2(WIDTH) bits; terminal count WIDTH-1; counter SHALL not wrap inside RUN.
REQ-026 sum, co and ovf SHALL retain the last result through IDLE until the next DONE.
REQ-027 Gate-level cell has roughly 30 ns combinational path; the simulation clock period SHALL be at least 40 ns.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE, and SHALL clear the counter, operand registers, carry register, sum, co and ovf to 0.
REQ-029 Reset outputs: in_ready=1, out_valid=0, sum=0, co=0, ovf=0 from the first edge with rst=1.
REQ-030 rst asserted mid-RUN or in DONE SHALL abort the operation with no output produced; rst has priority over every handshake.

Structure
REQ-031 Shared package SHALL hold the FSM state typedef and the default WIDTH constant.
REQ-032 SHALL instantiate exactly one sub-module, the team's one-bit full adder `adder` (A, B, Ci -> S, Co); no other arithmetic.
REQ-033 All registers SHALL sit in the controller; the adder cell SHALL stay purely combinational.

Verification (WIDTH=8, 50 ns clock)
REQ-034 0x0F+0x01, ci=0 -> sum=0x10, co=0, ovf=0; out_valid rises exactly 8 cycles after acceptance.
REQ-035 0xFF+0x01, ci=0 -> sum=0x00, co=1, ovf=0; then 0x00+0x00, ci=1 -> sum=0x01, co=0.
REQ-036 0x7F+0x01 -> sum=0x80, ovf=1, co=0; 0x80+0x80 -> sum=0x00, co=1, ovf=1.
REQ-037 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and outputs stable; in_valid pulses during RUN/DONE are ignored and the result is unchanged.
REQ-038 Assert rst at RUN cycle 4 -> next edge in_ready=1, out_valid=0, sum=0; a fresh 0x12+0x34 -> sum=0x46.
REQ-039 Randomized self-check of 1000 operand sets against A+B+ci, with out_ready toggled randomly.
